// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw pad inputs in, conditioned level and strobes out.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  // Producer of raw button inputs, consumer of conditioned outputs
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  // The conditioner itself
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel push-button conditioning: synchronizer, stability-count debouncer,
// and single-cycle press / release / long-press strobes. All outputs registered.
module button_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_conditioner_if.slave  bus_if
);

  localparam int unsigned MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                       : HOLD_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_DONE = 2'd2
  } hold_state_e;

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] long_v;

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic             samp_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    hold_state_e      state_q;
    logic [CNT_W-1:0] hcnt_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
      level_d = level_q;
      dcnt_d  = '0;
      if (samp_q != level_q) begin
        if (dcnt_q >= DB_LAST) begin
          level_d = samp_q;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
    end

    // Two-flop synchronizer plus one sample register feeding the debouncer; level/count state
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        samp_q  <= 1'b0;
        level_q <= 1'b0;
        dcnt_q  <= '0;
      end else begin
        sync1_q <= bus_if.btn_raw[g];
        sync2_q <= sync1_q;
        samp_q  <= sync2_q;
        level_q <= level_d;
        dcnt_q  <= dcnt_d;
      end
    end

    // Hold-tracking FSM and edge strobes, registered alongside the debounced level
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= ST_IDLE;
        hcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= level_d & ~level_q;
        release_q <= ~level_d & level_q;
        long_q    <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (level_d) begin
              state_q <= ST_HELD;
              hcnt_q  <= '0;
            end
          end
          ST_HELD: begin
            // A fall on the firing edge takes priority: release without long
            if (!level_d) begin
              state_q <= ST_IDLE;
            end else if (hcnt_q >= HOLD_LAST) begin
              long_q  <= 1'b1;
              state_q <= ST_LONG_DONE;
            end else begin
              hcnt_q <= hcnt_q + CNT_W'(1);
            end
          end
          ST_LONG_DONE: begin
            if (!level_d) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end

    assign level_v[g]   = level_q;
    assign press_v[g]   = press_q;
    assign release_v[g] = release_q;
    assign long_v[g]    = long_q;
  end

  assign bus_if.btn_level   = level_v;
  assign bus_if.btn_press   = press_v;
  assign bus_if.btn_release = release_v;
  assign bus_if.btn_long    = long_v;

endmodule
